// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width and opcode encoding, also used by the control unit.
package alu_pkg;

  localparam int DATA_WIDTH = 16;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRA = 3'b111
  } alu_op_e;

endpackage

// File: rtl/alu_if.sv
// Execute-stage ALU bus: the control/decode side is master, the ALU is slave.
interface alu_if #(parameter int WIDTH = alu_pkg::DATA_WIDTH);

  logic [2:0]              ALUOp;
  logic signed [WIDTH-1:0] Operand1;
  logic signed [WIDTH-1:0] Operand2;
  logic signed [WIDTH-1:0] ALUOut;
  logic                    Zero;

  modport master (output ALUOp, Operand1, Operand2, input ALUOut, Zero);
  modport slave  (input ALUOp, Operand1, Operand2, output ALUOut, Zero);

endinterface

// File: rtl/alu_core.sv
// Combinational ALU core: pure function of opcode and the two signed operands.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  alu_op_e                 op,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] result
);

  localparam int SH_W = $clog2(WIDTH);

  // Only the low bits of b select the shift; the rest are ignored.
  logic [SH_W-1:0] sh;
  assign sh = b[SH_W-1:0];

  always_comb begin
    // NOTE: default assignment first so no path through the case can infer a latch.
    result = '0;
    unique case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      // Both operands are signed, so this is a true signed compare (safe on overflow).
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, (a < b)};
      ALU_SLL: result = a << sh;
      ALU_SRA: result = a >>> sh;
    endcase
  end

endmodule

// File: rtl/alu.sv
// Execute-stage ALU: combinational core followed by the registered result and Zero flag.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input logic  clk,
  input logic  rst_n,
  alu_if.slave bus
);

  logic signed [WIDTH-1:0] result;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op     (alu_op_e'(bus.ALUOp)),
    .a      (bus.Operand1),
    .b      (bus.Operand2),
    .result (result)
  );

  // Zero is computed from the same value being registered, so it always matches ALUOut.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register update on the same clock edge.
    if (!rst_n) begin
      bus.ALUOut <= '0;
      bus.Zero   <= 1'b1;
    end else begin
      bus.ALUOut <= result;
      bus.Zero   <= (result == '0);
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: expected results are queued at issue and compared one edge later.
module tb_alu;
  import alu_pkg::*;

  typedef struct {
    logic [15:0] res;
    logic        zero;
    string       tag;
  } exp_t;

  logic clk;
  logic rst_n;
  alu_if bus ();

  exp_t sb[$];
  int   total;
  int   bad;

  alu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference: integer arithmetic on sign-extended operands.
  function automatic logic [15:0] model(logic [2:0] op, logic [15:0] a, logic [15:0] b);
    int ia;
    int ib;
    int sh;
    int r;
    ia = int'($signed(a));
    ib = int'($signed(b));
    sh = int'(b[3:0]);
    r  = 0;
    case (op)
      3'd0: r = ia + ib;
      3'd1: r = ia - ib;
      3'd2: r = ia & ib;
      3'd3: r = ia | ib;
      3'd4: r = ia ^ ib;
      3'd5: r = (ia < ib) ? 1 : 0;
      3'd6: r = ia * (1 << sh);
      default: r = ia >>> sh;
    endcase
    return r[15:0];
  endfunction

  // Drive one operation on the falling edge and queue what must appear after the next rise.
  task automatic issue(input alu_op_e op, input int a, input int b,
                       input int res, input logic zero, input string tag);
    exp_t e;
    logic [31:0] a32;
    logic [31:0] b32;
    logic [31:0] r32;
    @(negedge clk);
    a32 = a;
    b32 = b;
    r32 = res;
    bus.ALUOp    = op;
    bus.Operand1 = a32[15:0];
    bus.Operand2 = b32[15:0];
    e.res  = r32[15:0];
    e.zero = zero;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic test_reset;
    exp_t e;
    rst_n = 1'b0;
    issue(ALU_ADD, 7, 9, 0, 1'b1, "reset_add");
    @(posedge clk); #1;
    e = sb.pop_front();
    total++;
    if (bus.ALUOut !== e.res || bus.Zero !== e.zero) begin
      bad++;
      $display("FAIL %s: got out=%h zero=%b, want out=%h zero=%b",
               e.tag, bus.ALUOut, bus.Zero, e.res, e.zero);
    end
    issue(ALU_OR, 3, 4, 0, 1'b1, "reset_or");
    @(posedge clk); #1;
    e = sb.pop_front();
    total++;
    if (bus.ALUOut !== e.res || bus.Zero !== e.zero) begin
      bad++;
      $display("FAIL %s: got out=%h zero=%b, want out=%h zero=%b",
               e.tag, bus.ALUOut, bus.Zero, e.res, e.zero);
    end
  endtask

  task automatic test_zero_operands;
    exp_t e;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      issue(alu_op_e'(k), 0, 0, 0, 1'b1, $sformatf("zero_op%0d", k));
      @(posedge clk); #1;
      e = sb.pop_front();
      total++;
      if (bus.ALUOut !== e.res || bus.Zero !== e.zero) begin
        bad++;
        $display("FAIL %s: got out=%h zero=%b, want out=%h zero=%b",
                 e.tag, bus.ALUOut, bus.Zero, e.res, e.zero);
      end
    end
  endtask

  task automatic vec(input alu_op_e op, input int a, input int b, input int res, input string tag);
    exp_t e;
    issue(op, a, b, res, (res == 0), tag);
    @(posedge clk); #1;
    e = sb.pop_front();
    total++;
    if (bus.ALUOut !== e.res || bus.Zero !== e.zero) begin
      bad++;
      $display("FAIL %s: got out=%h zero=%b, want out=%h zero=%b",
               e.tag, bus.ALUOut, bus.Zero, e.res, e.zero);
    end
  endtask

  task automatic test_vectors;
    vec(ALU_ADD,  30,  3,  33, "p_add");
    vec(ALU_SUB,  30,  3,  27, "p_sub");
    vec(ALU_AND,  30,  3,   2, "p_and");
    vec(ALU_OR,   30,  3,  31, "p_or");
    vec(ALU_XOR,  30,  3,  29, "p_xor");
    vec(ALU_SLT,  30,  3,   0, "p_slt");
    vec(ALU_SLL,  30,  3, 240, "p_sll");
    vec(ALU_SRA,  30,  3,   3, "p_sra");
    vec(ALU_ADD, -10,  2,  -8, "n_add");
    vec(ALU_SUB, -10,  2, -12, "n_sub");
    vec(ALU_AND, -10,  2,   2, "n_and");
    vec(ALU_OR,  -10,  2, -10, "n_or");
    vec(ALU_XOR, -10,  2, -12, "n_xor");
    vec(ALU_SLT, -10,  2,   1, "n_slt");
    vec(ALU_SLL, -10,  2, -40, "n_sll");
    vec(ALU_SRA, -10,  2,  -3, "n_sra");
    vec(ALU_ADD,  10, -4,   6, "s_add");
    vec(ALU_SUB,  10, -4,  14, "s_sub");
    vec(ALU_SLT,  10, -4,   0, "s_slt");
    vec(ALU_SLL,  10, -4, -24576, "s_sll_sh12");
    vec(ALU_SRA,  10, -4,   0, "s_sra_sh12");
    vec(ALU_ADD,  -1, -9, -10, "m_add");
    vec(ALU_SUB,  -1, -9,   8, "m_sub");
    vec(ALU_AND,  -1, -9,  -9, "m_and");
    vec(ALU_XOR,  -1, -9,   8, "m_xor");
    vec(ALU_SLT,  -1, -9,   0, "m_slt");
    vec(ALU_SRA,  -1, -9,  -1, "m_sra_sh7");
    vec(ALU_ADD, 32767, 1, -32768, "add_wrap");
    vec(ALU_SUB, -32768, 1, 32767, "sub_wrap");
    vec(ALU_SLT, -32768, 1, 1, "slt_ovf_lt");
    vec(ALU_SLT, 32767, -1, 0, "slt_ovf_ge");
    vec(ALU_SLL, 1, 15, -32768, "sll_max");
    vec(ALU_SRA, -32768, 15, -1, "sra_max");
  endtask

  // New random op every cycle; each result must show up exactly one edge after issue.
  task automatic test_back_to_back;
    exp_t e;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    for (int k = 0; k < 200; k++) begin
      op = 3'($urandom_range(7));
      a  = 16'($urandom);
      b  = (k % 4 == 0) ? a : 16'($urandom);
      r  = model(op, a, b);
      issue(alu_op_e'(op), int'($signed(a)), int'($signed(b)), int'($signed(r)), (r == 16'h0),
            $sformatf("b2b%0d_op%0d", k, op));
      @(posedge clk); #1;
      e = sb.pop_front();
      total++;
      if (bus.ALUOut !== e.res || bus.Zero !== e.zero) begin
        bad++;
        $display("FAIL %s: got out=%h zero=%b, want out=%h zero=%b",
                 e.tag, bus.ALUOut, bus.Zero, e.res, e.zero);
      end
    end
  endtask

  task automatic test_mid_reset;
    exp_t e;
    issue(ALU_ADD, 100, 23, 123, 1'b0, "mr_before");
    @(posedge clk); #1;
    e = sb.pop_front();
    total++;
    if (bus.ALUOut !== e.res || bus.Zero !== e.zero) begin
      bad++;
      $display("FAIL %s: got out=%h zero=%b, want out=%h zero=%b",
               e.tag, bus.ALUOut, bus.Zero, e.res, e.zero);
    end
    issue(ALU_SUB, 50, 8, 0, 1'b1, "mr_during");
    rst_n = 1'b0;
    @(posedge clk); #1;
    e = sb.pop_front();
    total++;
    if (bus.ALUOut !== e.res || bus.Zero !== e.zero) begin
      bad++;
      $display("FAIL %s: got out=%h zero=%b, want out=%h zero=%b",
               e.tag, bus.ALUOut, bus.Zero, e.res, e.zero);
    end
    issue(ALU_OR, 12, 3, 15, 1'b0, "mr_after");
    rst_n = 1'b1;
    @(posedge clk); #1;
    e = sb.pop_front();
    total++;
    if (bus.ALUOut !== e.res || bus.Zero !== e.zero) begin
      bad++;
      $display("FAIL %s: got out=%h zero=%b, want out=%h zero=%b",
               e.tag, bus.ALUOut, bus.Zero, e.res, e.zero);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.ALUOp    = 3'd0;
    bus.Operand1 = '0;
    bus.Operand2 = '0;
    test_reset();
    test_zero_operands();
    test_vectors();
    test_back_to_back();
    test_mid_reset();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
